// File: rtl/ofm_drain_serializer.sv
// Captures one PE-array result vector into a byte buffer and streams it out
// one byte per accepted beat with an incrementing, wrapping write address.
module ofm_drain_serializer #(
  parameter int NUM_OF_PE = 256,
  parameter int ADDR_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_OF_PE*8-1:0] OFM,
  input  logic [NUM_OF_PE-1:0]   valid,
  input  logic                   tile_start,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic [7:0]             out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   group_done,
  output logic                   overflow,
  output logic [15:0]            group_count
);

  localparam int IDX_W = (NUM_OF_PE > 1) ? $clog2(NUM_OF_PE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OF_PE - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [NUM_OF_PE*8-1:0] buf_r, buf_s, cap_data_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic [ADDR_W-1:0]      addr_r, addr_s;
  logic [7:0]             data_r, data_s;
  logic                   done_r, done_s;
  logic                   ovf_r, ovf_s;
  logic [15:0]            gcnt_r, gcnt_s;
  logic                   capture_s, xfer_s, last_xfer_s;

  assign capture_s   = |valid;
  assign xfer_s      = (state_r == DRAIN) && out_ready;
  assign last_xfer_s = xfer_s && (idx_r == LAST_IDX);

  // Lanes without a valid result are stored as zero.
  always_comb begin
    cap_data_s = '0;
    for (int m = 0; m < NUM_OF_PE; m++) begin
      if (valid[m]) begin
        cap_data_s[m*8 +: 8] = OFM[m*8 +: 8];
      end else begin
        cap_data_s[m*8 +: 8] = 8'h00;
      end
    end
  end

  // Next-state, pointer, buffer and status computation.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    idx_s   = idx_r;
    addr_s  = addr_r;
    done_s  = 1'b0;
    ovf_s   = ovf_r;
    gcnt_s  = gcnt_r;
    case (state_r)
      IDLE: begin
        if (tile_start) begin
          addr_s = base_addr;
          ovf_s  = 1'b0;
          gcnt_s = 16'd0;
        end else begin
          addr_s = addr_r;
        end
        if (capture_s) begin
          buf_s   = cap_data_s;
          idx_s   = '0;
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (xfer_s) begin
          idx_s  = idx_r + IDX_ONE;
          addr_s = addr_r + ADDR_ONE;
        end else begin
          idx_s  = idx_r;
          addr_s = addr_r;
        end
        // A capture on the final beat starts the next group with no bubble.
        if (last_xfer_s) begin
          done_s = 1'b1;
          gcnt_s = gcnt_r + 16'd1;
          idx_s  = '0;
          if (capture_s) begin
            buf_s   = cap_data_s;
            state_s = DRAIN;
          end else begin
            state_s = IDLE;
          end
        end else if (capture_s) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = ovf_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
    data_s = buf_s[{idx_s, 3'b000} +: 8];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      buf_r   <= '0;
      idx_r   <= '0;
      addr_r  <= '0;
      data_r  <= 8'h00;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      gcnt_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      idx_r   <= idx_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      done_r  <= done_s;
      ovf_r   <= ovf_s;
      gcnt_r  <= gcnt_s;
    end
  end

  assign out_data    = data_r;
  assign out_addr    = addr_r;
  assign out_valid   = (state_r == DRAIN);
  assign busy        = (state_r == DRAIN);
  assign group_done  = done_r;
  assign overflow    = ovf_r;
  assign group_count = gcnt_r;

endmodule

// File: tb/tb_ofm_drain_serializer.sv
// Randomized scenario bench for ofm_drain_serializer; expected beats come from
// a queue model built directly from the capture/addressing rules.
module tb_ofm_drain_serializer;

  localparam int NPE = 256;
  localparam int AW  = 16;

  typedef struct packed {
    logic [7:0]    d;
    logic [AW-1:0] a;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NPE*8-1:0] OFM;
  logic [NPE-1:0]   valid;
  logic             tile_start;
  logic [AW-1:0]    base_addr;
  logic [7:0]       out_data;
  logic [AW-1:0]    out_addr;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             group_done;
  logic             overflow;
  logic [15:0]      group_count;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  int    gd_count;
  int    stall_changes;
  int    valid_cycles;

  ofm_drain_serializer #(.NUM_OF_PE(NPE), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .OFM(OFM), .valid(valid),
    .tile_start(tile_start), .base_addr(base_addr),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .group_done(group_done),
    .overflow(overflow), .group_count(group_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NPE*8-1:0] rand_ofm();
    logic [NPE*8-1:0] r;
    for (int m = 0; m < NPE; m++) r[m*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  // Reference model: beat k of a group is lane k (zero if not valid) at base+k mod 2^16.
  task automatic model_group(input logic [NPE*8-1:0] o, input logic [NPE-1:0] v,
                             input logic [AW-1:0] base, input int first_beat);
    beat_t b;
    for (int m = 0; m < NPE; m++) begin
      b.d = v[m] ? o[m*8 +: 8] : 8'h00;
      b.a = AW'((int'(base) + first_beat + m) % 65536);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_capture(input logic [NPE*8-1:0] o, input logic [NPE-1:0] v,
                            input logic ts, input logic [AW-1:0] b);
    @(negedge clk);
    OFM = o; valid = v; tile_start = ts; base_addr = b; out_ready = 1'b1;
  endtask

  // Drives out_ready and records transferred beats; mode 0 ready, 1 toggle (stall first), 2 random.
  task automatic collect(input int max_cycles, input int mode, input int inj_beat,
                         input logic [NPE*8-1:0] inj_ofm, input logic [NPE-1:0] inj_valid,
                         input int stop_beats);
    logic [7:0]    pd;
    logic [AW-1:0] pa;
    logic          stalled, rdy;
    beat_t         b;
    int            cyc;
    obs_q.delete(); gd_count = 0; stall_changes = 0; valid_cycles = 0;
    stalled = 1'b0; cyc = 0; pd = 8'h00; pa = '0;
    while (cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      OFM = '0; valid = '0; tile_start = 1'b0;
      if (group_done) gd_count++;
      if (out_valid) valid_cycles++;
      if (stalled && out_valid && (out_data !== pd || out_addr !== pa)) stall_changes++;
      if (!out_valid && obs_q.size() > 0) break;
      if (stop_beats > 0 && obs_q.size() == stop_beats) break;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = cyc[0] ? 1'b0 : 1'b1;
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (obs_q.size() == inj_beat) begin
          OFM = inj_ofm; valid = inj_valid;
        end
        b.d = out_data; b.a = out_addr;
        obs_q.push_back(b);
      end
      stalled = out_valid && !rdy;
      pd = out_data; pa = out_addr;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; OFM = rand_ofm(); valid = '1; tile_start = 1'b1;
    base_addr = 16'h1234; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, busy, group_done, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {out_valid, busy, group_done, overflow});
    end
    n_checks++;
    if (out_addr !== 16'h0000 || out_data !== 8'h00 || group_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_regs: addr %h data %h cnt %h, expected all zero", out_addr, out_data, group_count);
    end
    OFM = '0; valid = '0; tile_start = 1'b0; reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [NPE*8-1:0] o;
    for (int m = 0; m < NPE; m++) o[m*8 +: 8] = 8'(m);
    exp_q.delete();
    model_group(o, '1, 16'h0100, 0);
    do_capture(o, '1, 1'b1, 16'h0100);
    collect(2000, 0, -1, '0, '0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_beats: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL basic_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (gd_count != 1 || group_count !== 16'd1 || valid_cycles != NPE) begin
      n_fail++; $display("FAIL basic_done: gd %0d cnt %0d vcyc %0d, expected 1 1 %0d", gd_count, group_count, valid_cycles, NPE);
    end
  endtask

  task automatic test_stall();
    logic [NPE*8-1:0] o;
    o = rand_ofm();
    exp_q.delete();
    model_group(o, '1, 16'h0100, 0);
    do_capture(o, '1, 1'b1, 16'h0100);
    collect(3000, 1, -1, '0, '0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_beats: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (stall_changes != 0) begin
      n_fail++; $display("FAIL stall_hold: got %0d changes while stalled, expected 0", stall_changes);
    end
    n_checks++;
    if (valid_cycles != 2 * NPE || gd_count != 1) begin
      n_fail++; $display("FAIL stall_cycles: got %0d cycles gd %0d, expected %0d gd 1", valid_cycles, gd_count, 2 * NPE);
    end
  endtask

  task automatic test_partial_valid();
    logic [NPE*8-1:0] o;
    logic [NPE-1:0]   v;
    int               nz;
    o = rand_ofm();
    v = '0; v[3:0] = 4'hF;
    exp_q.delete();
    model_group(o, v, 16'h0800, 0);
    do_capture(o, v, 1'b1, 16'h0800);
    collect(3000, 2, -1, '0, '0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size() || stall_changes != 0) begin
      n_fail++; $display("FAIL partial_beats: got %0d beats %0d stall changes, expected %0d and 0", obs_q.size(), stall_changes, exp_q.size());
    end
    nz = 0;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL partial_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
      if (k >= 4 && obs_q[k].d !== 8'h00) nz++;
    end
    n_checks++;
    if (nz != 0) begin
      n_fail++; $display("FAIL partial_zero_lanes: got %0d nonzero bytes in lanes 4+, expected 0", nz);
    end
  endtask

  task automatic test_overflow();
    logic [NPE*8-1:0] o1, o2;
    o1 = rand_ofm(); o2 = rand_ofm();
    exp_q.delete();
    model_group(o1, '1, 16'h0100, 0);
    do_capture(o1, '1, 1'b1, 16'h0100);
    collect(2000, 0, 100, o2, '1, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_beats: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL ovf_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || gd_count != 1 || group_count !== 16'd1) begin
      n_fail++; $display("FAIL ovf_flag: ovf %b gd %0d cnt %0d, expected 1 1 1", overflow, gd_count, group_count);
    end
    @(negedge clk); tile_start = 1'b1; base_addr = 16'h0100;
    @(negedge clk); tile_start = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || group_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf %b cnt %0d busy %b, expected 0 0 0", overflow, group_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [NPE*8-1:0] o1, o2;
    o1 = rand_ofm(); o2 = rand_ofm();
    exp_q.delete();
    model_group(o1, '1, 16'h0100, 0);
    model_group(o2, '1, 16'h0100, NPE);
    do_capture(o1, '1, 1'b1, 16'h0100);
    collect(4000, 0, NPE - 1, o2, '1, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_beats: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (valid_cycles != 2 * NPE || gd_count != 2 || group_count !== 16'd2 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL b2b_status: vcyc %0d gd %0d cnt %0d ovf %b, expected %0d 2 2 0", valid_cycles, gd_count, group_count, overflow, 2 * NPE);
    end
  endtask

  task automatic test_wrap();
    logic [NPE*8-1:0] o;
    o = rand_ofm();
    exp_q.delete();
    model_group(o, '1, 16'hFFF0, 0);
    @(negedge clk); tile_start = 1'b1; base_addr = 16'hFFF0;
    do_capture(o, '1, 1'b0, 16'h5555);
    collect(2000, 0, -1, '0, '0, 0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_beats: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL wrap_beat[%0d]: got %h, expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (obs_q.size() > 16 && (obs_q[15].a !== 16'hFFFF || obs_q[16].a !== 16'h0000)) begin
      n_fail++; $display("FAIL wrap_edge: got %h,%h, expected ffff,0000", obs_q[15].a, obs_q[16].a);
    end
  endtask

  task automatic test_reset_mid_drain();
    int gd_after;
    do_capture(rand_ofm(), '1, 1'b1, 16'h0300);
    collect(2000, 0, -1, '0, '0, 0);
    do_capture(rand_ofm(), '1, 1'b0, 16'h0000);
    collect(2000, 0, -1, '0, '0, 50);
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== 16'h0432 || group_count !== 16'd1) begin
      n_fail++; $display("FAIL rst_mid_pre: valid %b addr %h cnt %0d, expected 1 0432 1", out_valid, out_addr, group_count);
    end
    reset_n = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, group_done} !== 3'b000 || out_addr !== 16'h0000 || group_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid: vbd %b addr %h cnt %0d, expected 000 0000 0", {out_valid, busy, group_done}, out_addr, group_count);
    end
    reset_n = 1'b1;
    gd_after = 0;
    repeat (5) begin
      @(negedge clk);
      if (group_done || out_valid) gd_after++;
    end
    n_checks++;
    if (gd_after != 0) begin
      n_fail++; $display("FAIL rst_mid_after: got %0d cycles with done/valid, expected 0", gd_after);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_partial_valid();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
